// File: rtl/conv1_src.sv
// conv1_src: flop-backed binarized image source for the first conv stage.
// The host loads the frame a row at a time. A start pulse then streams the
// frame out one pixel per transfer in raster order, with valid/ready
// handshake, row/col tags and frame markers.
module conv1_src #(
   parameter int WIDTH  = 28,
   parameter int HEIGHT = 28,
   parameter int RW     = 5,
   parameter int CW     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [RW-1:0]    wr_row,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             pixel_ready,
   output logic             pixel_out,
   output logic             pixel_valid,
   output logic [RW-1:0]    pix_row,
   output logic [CW-1:0]    pix_col,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_t;

   // One extra bit so the row bound still compares correctly when 2^RW == HEIGHT.
   localparam logic [RW:0]   ROW_LIMIT = (RW+1)'(HEIGHT);
   localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [RW-1:0]    row_idx;
   logic [RW-1:0]    row_next;
   logic [CW-1:0]    col_idx;
   logic [CW-1:0]    col_next;
   logic [WIDTH-1:0] mem [HEIGHT];

   logic wr_commit;
   logic at_first;
   logic at_last;
   logic xfer;

   // Writes are blocked while streaming so the frame stays stable.
   // Out-of-range rows are dropped.
   assign wr_commit = wr_en && (state != STREAM) && ({1'b0, wr_row} < ROW_LIMIT);
   assign at_first  = (row_idx == '0) && (col_idx == '0);
   assign at_last   = (row_idx == LAST_ROW) && (col_idx == LAST_COL);
   assign xfer      = pixel_valid && pixel_ready;

   // Frame storage lives in flops so any pixel can be read combinationally;
   // reset wipes the whole image.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < HEIGHT; r++) begin
            mem[r] <= '0;
         end
      end else if (wr_commit) begin
         mem[wr_row] <= wr_data;
      end
   end

   // State and raster position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         row_idx <= '0;
         col_idx <= '0;
      end else begin
         state   <= state_next;
         row_idx <= row_next;
         col_idx <= col_next;
      end
   end

   // Next state: advance the raster position only on an accepted transfer.
   // The final pixel parks the indices at the origin for the next frame.
   always_comb begin
      state_next = state;
      row_next   = row_idx;
      col_next   = col_idx;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = STREAM;
               row_next   = '0;
               col_next   = '0;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (at_last) begin
                  state_next = DONE;
                  row_next   = '0;
                  col_next   = '0;
               end else if (col_idx == LAST_COL) begin
                  col_next = '0;
                  row_next = row_idx + 1'b1;
               end else begin
                  col_next = col_idx + 1'b1;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode: the pixel data and tags are forced to zero whenever no
   // pixel is being offered, so the consumer never sees stale values.
   always_comb begin
      pixel_valid = (state == STREAM);
      busy        = (state == STREAM);
      done        = (state == DONE);
      pixel_out   = 1'b0;
      pix_row     = '0;
      pix_col     = '0;
      sof         = 1'b0;
      eof         = 1'b0;
      if (state == STREAM) begin
         pixel_out = mem[row_idx][col_idx];
         pix_row   = row_idx;
         pix_col   = col_idx;
         sof       = at_first;
         eof       = at_last;
      end
   end

endmodule

// File: doc/conv1_src.md
Name: conv1_src

Overview:
- Frame source for the first convolution stage: holds one binarized WIDTH x HEIGHT MNIST image in flop storage and streams it out one 1-bit pixel per transfer, in raster order.
- Loaded row-by-row by the host/testbench side, then triggered by a start pulse.
- Output is the serial pixel stream consumed by the 3x3 line-buffer stage.
- Adds valid/ready flow control, row/col tags and frame markers.

Parameters:
- WIDTH, 28, pixels per row (columns).
- HEIGHT, 28, rows per frame.
- RW, 5, row-index width; must satisfy 2^RW >= HEIGHT.
- CW, 5, column-index width; must satisfy 2^CW >= WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  row-write strobe.
- wr_row  input  RW  row address for the write.
- wr_data  input  WIDTH  row pixels; bit c = column c (LSB = column 0).
- start  input  1  single-cycle frame start request.
- pixel_ready  input  1  downstream accept; tie high for a consumer with no backpressure.
- pixel_out  output  1  current pixel value.
- pixel_valid  output  1  pixel_out/tags are valid.
- pix_row  output  RW  row index of current pixel.
- pix_col  output  CW  column index of current pixel.
- sof  output  1  high with valid on pixel (0,0).
- eof  output  1  high with valid on pixel (HEIGHT-1, WIDTH-1).
- busy  output  1  high while in STREAM.
- done  output  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (async assert, sync-released use):
  - state = IDLE.
  - Indices = 0.
  - All outputs = 0.
  - Image storage cleared to 0.
- Storage: HEIGHT x WIDTH bits in flops, not RAM.
- Writes:
  - Committed at the clock edge when wr_en=1, state != STREAM, and wr_row < HEIGHT.
  - wr_row >= HEIGHT: write is ignored.
  - wr_en during STREAM: write is ignored, so frame contents stay stable during streaming.
- States: IDLE, STREAM, DONE.
- IDLE:
  - busy=0, pixel_valid=0.
  - On start=1: go to STREAM, and row_idx/col_idx = 0.
  - A write in the same cycle as start is committed and is visible in the streamed frame.
- STREAM:
  - busy=1, pixel_valid=1.
  - pixel_out = mem[row_idx][col_idx], read combinationally from the flop array.
  - pix_row = row_idx, pix_col = col_idx.
  - sof = (row_idx==0 && col_idx==0); eof = (row_idx==HEIGHT-1 && col_idx==WIDTH-1).
  - Latency: pixel_valid rises the cycle after start is sampled.
- Transfer:
  - A transfer occurs on any edge where pixel_valid && pixel_ready.
  - On a transfer, col_idx increments. When col_idx wraps from WIDTH-1 to 0, row_idx increments.
  - On the eof transfer: go to DONE, and indices reset to 0.
- Stall rule: while pixel_ready=0, pixel_out, pix_row, pix_col, sof and eof hold unchanged and pixel_valid stays 1. Valid never drops mid-frame.
- Frame length: exactly WIDTH*HEIGHT transfers (784 at defaults).
- DONE:
  - Lasts one cycle, with done=1, pixel_valid=0, busy=0.
  - Next state is IDLE.
  - start sampled during DONE is ignored.
- start during STREAM: ignored, no restart.
- Re-stream: start from IDLE replays the stored image; storage is retained across frames.
- When pixel_valid=0: pixel_out, sof, eof, pix_row and pix_col are driven 0.
- Reset mid-stream: immediately returns to IDLE, outputs go to 0, storage is cleared. No done pulse is issued.
- Back-to-back frames: at least 2 idle cycles between eof transfer and the next first pixel (DONE + IDLE).

Test Plan:
- Reset values: assert rst_n=0 mid-run -> all outputs 0 same cycle. After release, start with no writes -> 784 pixels, all 0.
- Diagonal pattern: write row r with only bit r set (r=0..27), start, ready=1 -> pixel_valid rises 1 cycle after start, 784 consecutive transfers, pixel_out=1 exactly when pix_row==pix_col. sof on transfer 0, eof on transfer 783, done pulses the cycle after eof, busy falls with it.
- Backpressure: checkerboard image, pixel_ready driven random 50% -> pixel_out, pix_row and pix_col stable during every ready=0 cycle. Sequence still matches (row^col)&1. Total transfers = 784.
- Ignored controls: wr_en to row 3 with all-ones and a second start during STREAM -> row 3 streams old contents, frame length stays 784, no restart.
- Boundary writes: wr_row=28 with all-ones -> no storage change. Write row 0 in the same cycle as start -> first streamed row equals the new data.
- Mid-frame reset: rst_n low after 400 transfers -> pixel_valid=0, no done pulse. After reload and start, frame restarts at (0,0).
